// File: rtl/d_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals shared by d_mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the requesters plus the dMemBase data return.
interface d_mem_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        reqVec;
    logic [NREQ-1:0]        rwVec;
    logic [NREQ*ADDR_W-1:0] addrBus;
    logic [NREQ*DATA_W-1:0] wdataBus;
    logic [NREQ-1:0]        ackVec;
    logic [NREQ-1:0]        grantVec;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
    logic [ADDR_W-1:0]      memAddr;
    logic                   memEnable;
    logic [DATA_W-1:0]      memDataIn;
    logic                   memReadWrite;
    logic [DATA_W-1:0]      memDataOut;

    modport master (
        output reqVec, rwVec, addrBus, wdataBus, memDataOut,
        input  ackVec, grantVec, rdata, busy,
               memAddr, memEnable, memDataIn, memReadWrite
    );

    modport slave (
        input  reqVec, rwVec, addrBus, wdataBus, memDataOut,
        output ackVec, grantVec, rdata, busy,
               memAddr, memEnable, memDataIn, memReadWrite
    );
endinterface

// File: rtl/d_mem_arbiter.sv
// d_mem_arbiter: shares one dMemBase data memory between NREQ requesters.
// One transaction at a time: IDLE -> ISSUE -> (WAIT x RD_LAT) -> RESP -> IDLE.
// Optional feature macro: DMEM_ARB_RR_EN
//   defined   : rotating round-robin priority starting after the last winner
//   undefined : fixed priority, lowest requesting index always wins
module d_mem_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    d_mem_arbiter_if.slave     bus
);
    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WCNT_W = 2;   // RD_LAT is 1..4, counter runs RD_LAT-1 .. 0

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
`ifdef DMEM_ARB_RR_EN
    logic [IDX_W-1:0]    ptr_q, ptr_d;
`endif

    // Per-requester views of the flattened address / write-data buses.
    logic [ADDR_W-1:0]   addr_arr  [NREQ];
    logic [DATA_W-1:0]   wdata_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = bus.addrBus[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = bus.wdataBus[gi*DATA_W +: DATA_W];
    end

    logic [IDX_W-1:0]    win_idx;
    logic                win_found;

    // Winner selection over the live request vector (used only in IDLE).
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
`ifdef DMEM_ARB_RR_EN
        // Scan downward in rotation distance so the nearest candidate
        // after ptr is the last one written and therefore wins.
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.reqVec[(int'(ptr_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(ptr_q) + k) % NREQ);
            end
        end
`else
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.reqVec[k]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
`endif
    end

    // Next-state logic: sequencing and command/result register updates.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wcnt_d  = wcnt_q;
`ifdef DMEM_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_ISSUE;
                    grant_d = NREQ'(1) << win_idx;
                    rw_d    = bus.rwVec[win_idx];
                    addr_d  = addr_arr[win_idx];
                    wdata_d = wdata_arr[win_idx];
`ifdef DMEM_ARB_RR_EN
                    ptr_d   = win_idx;
`endif
                end
            end
            S_ISSUE: begin
                if (rw_q) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                    wcnt_d  = WCNT_W'(RD_LAT - 1);
                end
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    rdata_d = bus.memDataOut;
                    state_d = S_RESP;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wcnt_q  <= '0;
`ifdef DMEM_ARB_RR_EN
            ptr_q   <= IDX_W'(NREQ - 1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wcnt_q  <= wcnt_d;
`ifdef DMEM_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Memory pins come straight from state and the latched command, so a
    // reset drops them in the same instant the registers clear.
    assign bus.memEnable    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign bus.memReadWrite = (state_q == S_ISSUE) && rw_q;
    assign bus.memAddr      = addr_q;
    assign bus.memDataIn    = wdata_q;
    assign bus.ackVec       = (state_q == S_RESP) ? grant_q : '0;
    assign bus.grantVec     = grant_q;
    assign bus.rdata        = rdata_q;
    assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Testbench for d_mem_arbiter (RD_LAT = 3). Transaction-level reference model
// decides winners and completion cycles; a negedge monitor pops the
// expectation queue and compares against the DUT pins.
`timescale 1ns/1ps
module tb_d_mem_arbiter;
    localparam int NREQ   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    d_mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    d_mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory stand-in: data appears RD_LAT edges after the first enabled
    // read cycle; all other pipeline slots carry junk.
    logic [DATA_W-1:0] tb_mem  [256] = '{default: '0};
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    logic              en_prev = 1'b0;
    always @(posedge clk) begin
        en_prev <= bus.memEnable;
        if (bus.memEnable && bus.memReadWrite) tb_mem[bus.memAddr[7:0]] <= bus.memDataIn;
        rd_pipe[0] <= (bus.memEnable && !bus.memReadWrite && !en_prev) ? tb_mem[bus.memAddr[7:0]] : $urandom;
        for (int j = 1; j < RD_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign bus.memDataOut = rd_pipe[RD_LAT-1];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int                idx;
        int                issue_cyc;
        int                ack_cyc;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   ack_log[$];
    int   issue_log[$];

    logic [DATA_W-1:0] model_mem [256] = '{default: '0};
    bit                pend    [NREQ];
    bit                granted [NREQ];
    int                ack_at  [NREQ];
    int                gcyc    [NREQ];
    logic              c_rw    [NREQ];
    logic [ADDR_W-1:0] c_addr  [NREQ];
    logic [DATA_W-1:0] c_wdata [NREQ];
    int next_free = 0;
    int ptr       = NREQ - 1;
    int p_new     = 0;
    int p_keep    = 0;
    int force_rw  = -1;
    bit mutate    = 1'b0;

    task automatic set_cmd(int i, logic rw, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        pend[i] = 1'b1; c_rw[i] = rw; c_addr[i] = a; c_wdata[i] = d;
    endtask

    task automatic new_cmd(int i);
        logic rw;
        rw = (force_rw < 0) ? 1'($urandom_range(0, 1)) : (force_rw == 1);
        set_cmd(i, rw, ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 15), $urandom);
    endtask

    function automatic bit any_pend();
        for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_bus();
        for (int i = 0; i < NREQ; i++) begin
            bus.reqVec[i] = pend[i];
            if (granted[i] && mutate) begin
                bus.rwVec[i]                     = 1'($urandom_range(0, 1));
                bus.addrBus[i*ADDR_W +: ADDR_W]  = $urandom;
                bus.wdataBus[i*DATA_W +: DATA_W] = $urandom;
            end else begin
                bus.rwVec[i]                     = c_rw[i];
                bus.addrBus[i*ADDR_W +: ADDR_W]  = c_addr[i];
                bus.wdataBus[i*DATA_W +: DATA_W] = c_wdata[i];
            end
        end
    endtask

    // One clock: retire finished requesters, add arrivals, drive, arbitrate.
    task automatic step();
        int w;
        exp_t e;
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++)
            if (granted[i] && cyc == ack_at[i] + 1) begin
                granted[i] = 1'b0;
                if ($urandom_range(0, 99) < p_keep) new_cmd(i); else pend[i] = 1'b0;
            end
        for (int i = 0; i < NREQ; i++)
            if (!pend[i] && $urandom_range(0, 99) < p_new) new_cmd(i);
        drive_bus();
        if (cyc >= next_free && any_pend()) begin
            w = -1;
`ifdef DMEM_ARB_RR_EN
            for (int k = 1; k <= NREQ && w < 0; k++)
                if (pend[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
`else
            for (int k = 0; k < NREQ && w < 0; k++)
                if (pend[k]) w = k;
`endif
            e.idx       = w;
            e.issue_cyc = cyc + 1;
            e.ack_cyc   = c_rw[w] ? cyc + 2 : cyc + 2 + RD_LAT;
            e.rw        = c_rw[w];
            e.addr      = c_addr[w];
            e.wdata     = c_wdata[w];
            if (c_rw[w]) begin
                model_mem[c_addr[w][7:0]] = c_wdata[w];
                e.rdata = '0;
            end else begin
                e.rdata = model_mem[c_addr[w][7:0]];
            end
            exp_q.push_back(e);
            granted[w] = 1'b1;
            ack_at[w]  = e.ack_cyc;
            gcyc[w]    = cyc;
            next_free  = e.ack_cyc + 1;
            ptr        = w;
        end
    endtask

    task automatic drain(string name, int budget);
        int n = 0;
        p_new = 0; p_keep = 0;
        while ((any_pend() || cyc < next_free) && n < budget) begin step(); n++; end
        chk({name, "_done"}, 64'(n < budget), 64'd1);
    endtask

    // ---------------- monitor ----------------
    logic mon_en_prev = 1'b0;
    always @(negedge clk) begin
        int a_idx;
        if (reset) begin
            if (bus.memEnable && !mon_en_prev) issue_log.push_back(cyc);
            mon_en_prev = bus.memEnable;
            if (exp_q.size() > 0 && cyc == exp_q[0].issue_cyc) begin
                chk("issue_en",   64'(bus.memEnable),    64'd1);
                chk("issue_rw",   64'(bus.memReadWrite), 64'(exp_q[0].rw));
                chk("issue_addr", 64'(bus.memAddr),      64'(exp_q[0].addr));
                chk("issue_gnt",  64'(bus.grantVec),     64'(1 << exp_q[0].idx));
                if (exp_q[0].rw) chk("issue_wdata", 64'(bus.memDataIn), 64'(exp_q[0].wdata));
            end
            if (exp_q.size() > 0 && !exp_q[0].rw && cyc > exp_q[0].issue_cyc && cyc < exp_q[0].ack_cyc) begin
                chk("wait_en",   64'(bus.memEnable),    64'd1);
                chk("wait_rw",   64'(bus.memReadWrite), 64'd0);
                chk("wait_addr", 64'(bus.memAddr),      64'(exp_q[0].addr));
            end
            a_idx = -1;
            for (int i = NREQ - 1; i >= 0; i--) if (bus.ackVec[i]) a_idx = i;
            if (a_idx >= 0) ack_log.push_back(a_idx);
            if (exp_q.size() > 0 && cyc == exp_q[0].ack_cyc) begin
                chk("ack_vec", 64'(bus.ackVec),    64'(1 << exp_q[0].idx));
                chk("ack_en",  64'(bus.memEnable), 64'd0);
                if (!exp_q[0].rw) chk("ack_rdata", 64'(bus.rdata), 64'(exp_q[0].rdata));
                $display("txn req%0d %s addr=%0h ack@%0d", exp_q[0].idx, exp_q[0].rw ? "WR" : "RD",
                         exp_q[0].addr, cyc);
                void'(exp_q.pop_front());
            end else if (bus.ackVec != '0) begin
                chk("unexpected_ack", 64'(bus.ackVec), 64'd0);
            end
        end else begin
            mon_en_prev = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int exp_order [5];
        reset = 1'b0;
        bus.reqVec = '0; bus.rwVec = '0; bus.addrBus = '0; bus.wdataBus = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; granted[i] = 0; c_rw[i] = 0; c_addr[i] = '0; c_wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",   64'(bus.ackVec),       64'd0);
        chk("rst_gnt",   64'(bus.grantVec),     64'd0);
        chk("rst_rdata", 64'(bus.rdata),        64'd0);
        chk("rst_busy",  64'(bus.busy),         64'd0);
        chk("rst_addr",  64'(bus.memAddr),      64'd0);
        chk("rst_en",    64'(bus.memEnable),    64'd0);
        chk("rst_din",   64'(bus.memDataIn),    64'd0);
        chk("rst_rw",    64'(bus.memReadWrite), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        next_free = cyc + 1;

        // Single write then read-back at address 7.
        set_cmd(0, 1'b1, 32'd7, 32'd20);
        drain("wr7", 20);
        set_cmd(0, 1'b0, 32'd7, 32'd0);
        drain("rd7", 20);
        chk("readback_20", 64'(bus.rdata), 64'd20);

        // Contention: all requesters held, each re-requests after its ack.
        ack_log.delete();
        p_keep = 100; force_rw = -1;
        for (int i = 0; i < NREQ; i++) new_cmd(i);
        n = 0;
        while (ack_log.size() < 5 && n < 200) begin step(); n++; end
        chk("contention_done", 64'(ack_log.size() >= 5), 64'd1);
`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        for (int k = 0; k < 5 && k < ack_log.size(); k++)
            chk($sformatf("grant_order%0d", k), 64'(ack_log[k]), 64'(exp_order[k]));
        drain("contention", 300);

        // Back-to-back writes from requester 1 held high across its ack.
        issue_log.delete();
        force_rw = 1; p_keep = 100;
        new_cmd(1);
        n = 0;
        while (issue_log.size() < 2 && n < 30) begin step(); n++; end
        chk("b2b_done", 64'(issue_log.size() >= 2), 64'd1);
        if (issue_log.size() >= 2) chk("b2b_gap", 64'(issue_log[1] - issue_log[0]), 64'd3);
        drain("b2b", 30);
        force_rw = -1;

        // Read whose address is scrambled on the bus while it is in flight.
        set_cmd(2, 1'b1, 32'd7, 32'hCAFE_0001);
        drain("mut_wr", 20);
        mutate = 1'b1;
        set_cmd(2, 1'b0, 32'd7, 32'd0);
        drain("mut_rd", 20);
        chk("mut_rdata", 64'(bus.rdata), 64'hCAFE_0001);

        // Randomized traffic.
        p_new = 30; p_keep = 40;
        for (int k = 0; k < 600; k++) step();
        drain("random", 400);
        mutate = 1'b0;

        // Reset during the second WAIT cycle of a read by requester 1.
        set_cmd(1, 1'b0, 32'd9, 32'd0);
        n = 0;
        while (!(granted[1] && cyc == gcyc[1] + 3) && n < 20) begin step(); n++; end
        chk("rstwait_reach", 64'(n < 20), 64'd1);
        reset = 1'b0;
        #1;
        chk("rstwait_en",   64'(bus.memEnable), 64'd0);
        chk("rstwait_busy", 64'(bus.busy),      64'd0);
        chk("rstwait_gnt",  64'(bus.grantVec),  64'd0);
        chk("rstwait_ack",  64'(bus.ackVec),    64'd0);
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) begin pend[i] = 0; granted[i] = 0; end
        ptr = NREQ - 1;
        drive_bus();
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        next_free = cyc + 1;
        ack_log.delete();
        for (int i = 0; i < NREQ; i++) new_cmd(i);
        n = 0;
        while (ack_log.size() < 1 && n < 30) begin step(); n++; end
        chk("post_rst_done", 64'(ack_log.size() >= 1), 64'd1);
        if (ack_log.size() >= 1) chk("post_rst_first", 64'(ack_log[0]), 64'd0);
        drain("post_rst", 100);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/d_mem_arbiter.md
# d_mem_arbiter

Round-robin arbiter and sequencer that shares a single `dMemBase` data memory between `NREQ` requesters. Each requester raises a request with command, address and write data; the arbiter grants one at a time, drives the memory's `addr`/`enable`/`dataIn`/`readWrite` pins, waits the memory read latency, and returns an acknowledge plus read data. It sits between the load/store clients and `dMemBase`, which remains the only block touching the memory chips.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `RD_LAT`, 1: cycles from end of ISSUE to valid `memDataOut`, 1..4.

- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `reqVec`  input  NREQ  request per requester, held high until its ack.
- `rwVec`  input  NREQ  per-requester command: 1 write, 0 read.
- `addrBus`  input  NREQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- `wdataBus`  input  NREQ*DATA_W  flattened write data, same packing.
- `ackVec`  output  NREQ  one-cycle one-hot completion pulse.
- `grantVec`  output  NREQ  one-hot owner, high from ISSUE through RESP.
- `rdata`  output  DATA_W  read data, valid only in the ack cycle of a read.
- `busy`  output  1  high whenever state is not IDLE.
- `memAddr`  output  ADDR_W  to `dMemBase.addr`.
- `memEnable`  output  1  to `dMemBase.enable`.
- `memDataIn`  output  DATA_W  to `dMemBase.dataIn`.
- `memReadWrite`  output  1  to `dMemBase.readWrite` (1 write, 0 read).
- `memDataOut`  input  DATA_W  from `dMemBase.dataOut`.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `reqVec` bit is set, select a winner, latch its `rwVec` bit, address and write data into command registers, set `grantVec`, go ISSUE. Otherwise stay.
- Winner selection: the first set bit scanning upward (with wrap) from `ptr+1`, where `ptr` is the last granted index. `ptr` updates to the winner on grant.
- ISSUE, one cycle: `memEnable`=1, `memAddr`/`memDataIn` come from the latched command, and `memReadWrite`=latched rw. A write goes to RESP; a read goes to WAIT.
- WAIT, `RD_LAT` cycles: `memEnable`=1, `memReadWrite`=0, address held. On the last WAIT edge, capture `memDataOut` into `rdata`, then go RESP.
- RESP, one cycle: `ackVec[winner]`=1, `memEnable`=0. Next state is IDLE. `grantVec` clears on exit.
- `rdata` holds its last captured value outside the ack cycle. Write acks leave `rdata` unchanged.
- Requester inputs are sampled only in IDLE. Changes during ISSUE, WAIT or RESP are ignored.
- A requester that keeps `req` high after its ack is treated as a new request in the next IDLE.

## Timing
- Reset (async, `reset`=0): state IDLE, `ptr`=NREQ-1 (so index 0 wins first), and all outputs 0, including `ackVec`, `grantVec`, `rdata`, `busy`, `memAddr`, `memEnable`, `memDataIn` and `memReadWrite`.
- Reset mid-operation: memory outputs drop immediately, no ack is issued, and the pending transaction is lost.
- If a request is first seen in IDLE during cycle t:
  - ISSUE is cycle t+1.
  - A write acks at t+2.
  - A read acks at t+2+RD_LAT.
- There is at least one IDLE cycle between transactions, so back-to-back writes complete every 3 cycles and reads every 3+RD_LAT cycles.
- Simultaneous requests resolve in one cycle by rotating priority. No requester waits more than NREQ-1 other transactions.
- A request that arrives during RESP is seen in the following IDLE cycle.

## Configuration
- `DMEM_ARB_RR_EN` defined: rotating round-robin priority as described above.
- `DMEM_ARB_RR_EN` undefined: fixed priority, with the lowest set index always winning. `ptr` is not implemented. Latency per transaction is unchanged.

## Test plan
- Reset then single write: req0, rw=1, addr=7, data=20 at t → `memEnable`=1 and `memReadWrite`=1 with addr 7 at t+1; `ackVec`=0001 at t+2.
- Read-back: req0, rw=0, addr=7 after the write → ack at t+2+RD_LAT with `rdata`=20. `memReadWrite` stays 0 throughout.
- Contention with round-robin: all four requesters held high with distinct addresses → grants in order 0,1,2,3,0. Without `DMEM_ARB_RR_EN`, the grant order is 0,0,0 while req0 is held.
- Back-to-back: req1 held high across its ack → second ISSUE exactly 3 cycles after the first for a write. `ackVec` pulses are one cycle wide.
- Reset during WAIT (RD_LAT=3, `reset` pulled low in the second WAIT cycle) → `memEnable`=0 at once, no ack, state IDLE, and the next grant goes to requester 0.
- Input change during WAIT: requester changes `addrBus` mid-read → `memAddr` holds the latched address and `rdata` returns data from the original address.
